// File: rtl/icmp_echo_buf.sv
// Single-packet ICMP echo payload buffer: captures request bytes, then replays them to the tx path.
// Optional abort timer in START/SEND is enabled by defining ICMP_ECHO_TIMEOUT_EN.
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | empty, waiting for the first byte or an empty packet
// S_RECV  | storing payload bytes until rec_pkt_done
// S_START | one-cycle tx_start_en pulse, read pointer rewound
// S_SEND  | serving bytes on tx_req until tx_done
module icmp_echo_buf #(
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        len_mismatch,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_START, S_SEND} state_t;

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, wptr_nx;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [15:0]     byte_num_q, byte_num_d;
  logic            len_mis_q, len_mis_d;
  logic [15:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            drop_ovf, drop_busy, drop_tmo;
  logic            wr_en, rd_en;
  logic            tmo;
  logic [16:0]     drop_sum;

  logic [7:0]      mem [DEPTH];
  logic [7:0]      ram_rd_q;

`ifdef ICMP_ECHO_TIMEOUT_EN
  // Down-counter loaded on entry to START; terminal count aborts the reply.
  logic [15:0] tmr_q, tmr_d;

  assign tmo = ((state_q == S_START) || (state_q == S_SEND)) && (tmr_q == 16'd0);

  always_comb begin
    tmr_d = tmr_q;
    if ((state_d == S_START) && (state_q != S_START))
      tmr_d = 16'(TIMEOUT - 1);
    else if (((state_q == S_START) || (state_q == S_SEND)) && (tmr_q != 16'd0))
      tmr_d = tmr_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    wptr_nx    = wptr_q;
    rptr_d     = rptr_q;
    byte_num_d = byte_num_q;
    len_mis_d  = len_mis_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    drop_ovf   = 1'b0;
    drop_busy  = 1'b0;
    drop_tmo   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    case (state_q)
      S_IDLE, S_RECV: begin
        if (rec_en) begin
          if (wptr_q < DEPTH_P) begin
            wr_en   = 1'b1;
            wptr_nx = wptr_q + PW'(1);
          end else if (!ovf_q) begin
            ovf_d    = 1'b1;
            drop_ovf = 1'b1;
          end
          wptr_d  = wptr_nx;
          state_d = S_RECV;
        end
        // A byte arriving with rec_pkt_done is already counted in wptr_nx.
        if (rec_pkt_done) begin
          byte_num_d = 16'(wptr_nx);
          if (16'(wptr_nx) != rec_byte_num) len_mis_d = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        rptr_d    = '0;
        drop_busy = rec_pkt_done;
        state_d   = S_SEND;
      end
      S_SEND: begin
        drop_busy = rec_pkt_done;
        if (tx_req) begin
          if (16'(rptr_q) < byte_num_q) begin
            rd_en  = 1'b1;
            zero_d = 1'b0;
            rptr_d = rptr_q + PW'(1);
          end else begin
            zero_d = 1'b1;
          end
        end
        if (tx_done) begin
          wptr_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tmo && (state_d != S_IDLE)) begin
      state_d  = S_IDLE;
      wptr_d   = '0;
      rptr_d   = '0;
      drop_tmo = 1'b1;
    end
  end

  assign drop_sum = {1'b0, drop_q} + 17'(drop_ovf) + 17'(drop_busy) + 17'(drop_tmo);
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      byte_num_q <= '0;
      len_mis_q  <= 1'b0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      byte_num_q <= byte_num_d;
      len_mis_q  <= len_mis_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ADDR_W-1:0]] <= rec_data;
  end

  // Registered read port with synchronous output reset maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst)        ram_rd_q <= '0;
    else if (rd_en) ram_rd_q <= mem[rptr_q[ADDR_W-1:0]];
  end

  assign tx_start_en  = (state_q == S_START);
  assign busy         = (state_q != S_IDLE);
  assign tx_byte_num  = byte_num_q;
  assign tx_data      = zero_q ? 8'h00 : ram_rd_q;
  assign len_mismatch = len_mis_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_icmp_echo_buf.sv
// Directed bench for icmp_echo_buf: a default-depth instance plus a DEPTH=16 instance
// for overflow (and the abort timer when ICMP_ECHO_TIMEOUT_EN is defined).
module tb_icmp_echo_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst16 = 1'b1;
  logic        rec_en = 1'b0;
  logic [7:0]  rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;

  logic        a_start, a_busy, a_mis;
  logic [15:0] a_num, a_drop;
  logic [7:0]  a_data;
  logic        b_start, b_busy, b_mis;
  logic [15:0] b_num, b_drop;
  logic [7:0]  b_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icmp_echo_buf dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(a_start),
    .tx_byte_num(a_num), .tx_data(a_data), .busy(a_busy),
    .len_mismatch(a_mis), .drop_cnt(a_drop)
  );

  icmp_echo_buf #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(100)) dut16 (
    .clk(clk), .rst(rst16), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
    .tx_req(tx_req), .tx_done(tx_done), .tx_start_en(b_start),
    .tx_byte_num(b_num), .tx_data(b_data), .busy(b_busy),
    .len_mismatch(b_mis), .drop_cnt(b_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams n bytes base+i, then closes; the last byte optionally shares the close cycle.
  task automatic send_pkt(input int n, input logic [7:0] base, input logic [15:0] rbn,
                          input bit same_cycle);
    for (int i = 0; i < n; i++) begin
      rec_en   = 1'b1;
      rec_data = base + 8'(i);
      if (same_cycle && i == n - 1) begin
        rec_pkt_done = 1'b1;
        rec_byte_num = rbn;
      end
      tick();
    end
    rec_en = 1'b0;
    if (!(same_cycle && n > 0)) begin
      rec_pkt_done = 1'b1;
      rec_byte_num = rbn;
      tick();
    end
    rec_pkt_done = 1'b0;
  endtask

  task automatic end_tx();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst   = 1'b0;
    rst16 = 1'b0;
    chk("rst_start", 32'(a_start), 32'd0);
    chk("rst_num",   32'(a_num),   32'd0);
    chk("rst_data",  32'(a_data),  32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_mis",   32'(a_mis),   32'd0);
    chk("rst_drop",  32'(a_drop),  32'd0);

    // Basic 32-byte echo
    send_pkt(32, 8'h00, 16'd32, 1'b0);
    chk("echo_start", 32'(a_start), 32'd1);
    chk("echo_num",   32'(a_num),   32'd32);
    chk("echo_busy",  32'(a_busy),  32'd1);
    tick();
    chk("echo_start_pulse", 32'(a_start), 32'd0);
    tx_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("echo_data%0d", i), 32'(a_data), 32'(i));
    end
    tx_req = 1'b0;
    chk("echo_num_stable", 32'(a_num), 32'd32);
    end_tx();
    chk("echo_idle", 32'(a_busy), 32'd0);
    chk("echo_mis",  32'(a_mis),  32'd0);

    // Last byte coincides with rec_pkt_done
    send_pkt(4, 8'hA0, 16'd4, 1'b1);
    chk("same_start", 32'(a_start), 32'd1);
    chk("same_num",   32'(a_num),   32'd4);
    chk("same_mis",   32'(a_mis),   32'd0);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("same_data%0d", i), 32'(a_data), 32'hA0 + 32'(i));
    end
    tx_req = 1'b0;
    end_tx();

    // Request arriving during SEND is dropped, first reply intact
    send_pkt(8, 8'h40, 16'd8, 1'b0);
    tick();
    send_pkt(8, 8'h80, 16'd8, 1'b0);
    chk("bdrop_cnt",  32'(a_drop), 32'd1);
    chk("bdrop_busy", 32'(a_busy), 32'd1);
    chk("bdrop_num",  32'(a_num),  32'd8);
    tx_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("bdrop_data%0d", i), 32'(a_data), 32'h40 + 32'(i));
    end
    tx_req = 1'b0;
    end_tx();
    send_pkt(8, 8'hC0, 16'd8, 1'b0);
    chk("next_start", 32'(a_start), 32'd1);
    chk("next_drop",  32'(a_drop),  32'd1);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("next_data%0d", i), 32'(a_data), 32'hC0 + 32'(i));
    end
    tx_req = 1'b0;
    end_tx();

    // tx_req outside SEND leaves tx_data alone
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk("idle_req_hold", 32'(a_data), 32'hC7);

    // Empty packet: length 0, any read returns 0
    send_pkt(0, 8'h00, 16'd0, 1'b0);
    chk("empty_start", 32'(a_start), 32'd1);
    chk("empty_num",   32'(a_num),   32'd0);
    tick();
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    chk("empty_data", 32'(a_data), 32'd0);
    end_tx();

    // Reported length disagrees with stored count
    send_pkt(2, 8'h55, 16'd3, 1'b0);
    chk("mis_set", 32'(a_mis), 32'd1);
    tick();
    end_tx();
    chk("mis_sticky", 32'(a_mis), 32'd1);

    // Reset in the middle of SEND
    send_pkt(10, 8'h10, 16'd10, 1'b0);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("mid_data%0d", i), 32'(a_data), 32'h10 + 32'(i));
    end
    tx_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_start", 32'(a_start), 32'd0);
    chk("mid_rst_num",   32'(a_num),   32'd0);
    chk("mid_rst_data",  32'(a_data),  32'd0);
    chk("mid_rst_busy",  32'(a_busy),  32'd0);
    chk("mid_rst_mis",   32'(a_mis),   32'd0);
    chk("mid_rst_drop",  32'(a_drop),  32'd0);
    send_pkt(3, 8'h60, 16'd3, 1'b0);
    chk("post_rst_num", 32'(a_num), 32'd3);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_data%0d", i), 32'(a_data), 32'h60 + 32'(i));
    end
    tx_req = 1'b0;
    end_tx();

    // Overflow on the 16-byte instance
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    chk("ovf_rst_busy", 32'(b_busy), 32'd0);
    send_pkt(20, 8'h20, 16'd20, 1'b0);
    chk("ovf_start", 32'(b_start), 32'd1);
    chk("ovf_num",   32'(b_num),   32'd16);
    chk("ovf_drop",  32'(b_drop),  32'd1);
    chk("ovf_mis",   32'(b_mis),   32'd1);
    tick();
    tx_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("ovf_data%0d", i), 32'(b_data), 32'h20 + 32'(i));
    end
    tick();
    chk("ovf_beyond", 32'(b_data), 32'h00);
    tick();
    chk("ovf_beyond2", 32'(b_data), 32'h00);
    tx_req = 1'b0;
    end_tx();
    chk("ovf_idle", 32'(b_busy), 32'd0);
    chk("ovf_drop_final", 32'(b_drop), 32'd1);

`ifdef ICMP_ECHO_TIMEOUT_EN
    // Abort when tx_done never comes
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    send_pkt(1, 8'h77, 16'd1, 1'b0);
    chk("tmo_start", 32'(b_start), 32'd1);
    for (int i = 1; i < 100; i++) tick();
    chk("tmo_busy_99", 32'(b_busy), 32'd1);
    tick();
    chk("tmo_busy_100", 32'(b_busy), 32'd0);
    chk("tmo_drop", 32'(b_drop), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
